// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank read path: widths, FSM state
// encodings, operand indices and small operand-mask helpers.
package regbank_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;
  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  // FSM state encodings
  localparam state_t IDLE   = 3'd0;
  localparam state_t ADDR   = 3'd1;
  localparam state_t TOGGLE = 3'd2;
  localparam state_t GUARD  = 3'd3;
  localparam state_t WAIT   = 3'd4;
  localparam state_t DONE   = 3'd5;

  // Operand indices, also the bit positions in the use-mask
  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;

  // Program-counter register index; an ordinary index as far as fetch is concerned
  localparam logic [ADDR_W-1:0] REG_PC = 4'd15;

  // Lowest pending operand, scanning in the fixed order A, B, C
  function automatic logic [1:0] lowest_op(input logic [2:0] pend);
    logic [1:0] op;
    if (pend[0]) begin
      op = OP_A;
    end else if (pend[1]) begin
      op = OP_B;
    end else begin
      op = OP_C;
    end
    return op;
  endfunction

  // One-hot mask bit for an operand index
  function automatic logic [2:0] op_bit(input logic [1:0] op);
    logic [2:0] b;
    case (op)
      OP_A:    b = 3'b001;
      OP_B:    b = 3'b010;
      OP_C:    b = 3'b100;
      default: b = 3'b000;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/level_sync.sv
// Multi-flop synchronizer for a slowly changing level crossing into clk.
module level_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through the synchronizer chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch requester: reads up to three registers from the bank over a
// toggle-triggered read port and hands the operand set to the issuer.
module operand_fetch
  import regbank_pkg::*;
#(
  parameter int GUARD_CYCLES = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [ADDR_W-1:0] addrC,
  input  logic [2:0]        useMask,
  output logic              triggerOutr,
  output logic [ADDR_W-1:0] addrOut,
  input  logic              readyIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic              opValid,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  output logic [DATA_W-1:0] opC,
  input  logic              opAck,
  output logic              timeoutErr
);

  localparam int GCNT_W = $clog2(GUARD_CYCLES + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [GCNT_W-1:0] GUARD_LOAD = GCNT_W'(GUARD_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TIMEOUT - 1);

  // The guard window must cover the synchronizer delay, otherwise a stale
  // ready level from the previous read could be taken as the new one.
  if (GUARD_CYCLES < SYNC_STAGES) begin : g_bad_guard
    $error("operand_fetch: GUARD_CYCLES must be >= SYNC_STAGES");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("operand_fetch: TIMEOUT must be >= 1");
  end

  state_t            state_q, state_d;
  logic [2:0]        pend_q, pend_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [ADDR_W-1:0] addr_c_q, addr_c_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic              trig_q, trig_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] op_c_q, op_c_d;
  logic              op_valid_q, op_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              err_q, err_d;

  logic              ready_sync;
  logic [1:0]        cur_op;
  logic [2:0]        pend_left;

  level_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ready_sync (
    .clk(clk),
    .rst(reset),
    .d_i(readyIn),
    .q_o(ready_sync)
  );

  assign cur_op = lowest_op(pend_q);

  // Next-state logic for the fetch sequencer and its datapath registers
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    addr_c_d   = addr_c_q;
    addr_out_d = addr_out_q;
    trig_d     = trig_q;
    gcnt_d     = gcnt_q;
    tcnt_d     = tcnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_c_d     = op_c_q;
    op_valid_d = op_valid_q;
    err_d      = err_q;
    pend_left  = pend_q & ~op_bit(cur_op);

    case (state_q)
      IDLE: begin
        if (reqValid && req_ready_q) begin
          addr_a_d = addrA;
          addr_b_d = addrB;
          addr_c_d = addrC;
          pend_d   = useMask;
          op_a_d   = {DATA_W{1'b0}};
          op_b_d   = {DATA_W{1'b0}};
          op_c_d   = {DATA_W{1'b0}};
          if (useMask != 3'b000) begin
            state_d = ADDR;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        // Address goes out a full cycle ahead of the trigger edge
        case (cur_op)
          OP_A:    addr_out_d = addr_a_q;
          OP_B:    addr_out_d = addr_b_q;
          OP_C:    addr_out_d = addr_c_q;
          default: addr_out_d = addr_out_q;
        endcase
        tcnt_d  = {TCNT_W{1'b0}};
        state_d = TOGGLE;
      end
      TOGGLE: begin
        trig_d  = ~trig_q;
        gcnt_d  = GUARD_LOAD;
        state_d = GUARD;
      end
      GUARD: begin
        if (gcnt_q == {GCNT_W{1'b0}}) begin
          state_d = WAIT;
        end else begin
          gcnt_d = gcnt_q - GCNT_W'(1);
        end
      end
      WAIT: begin
        if (ready_sync) begin
          case (cur_op)
            OP_A:    op_a_d = dataIn;
            OP_B:    op_b_d = dataIn;
            OP_C:    op_c_d = dataIn;
            default: op_a_d = op_a_q;
          endcase
          pend_d = pend_left;
          if (pend_left != 3'b000) begin
            state_d = ADDR;
          end else begin
            state_d = DONE;
          end
        end else if (tcnt_q == TCNT_LAST) begin
          // Abort the whole set; operands not yet captured remain zero
          err_d   = 1'b1;
          pend_d  = 3'b000;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      DONE: begin
        // First DONE cycle raises valid; acknowledge is honoured only once
        // the issuer can actually have seen valid.
        if (!op_valid_q) begin
          op_valid_d = 1'b1;
        end else if (opAck) begin
          op_valid_d = 1'b0;
          state_d    = IDLE;
        end else begin
          op_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        op_valid_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 3'b000;
      addr_a_q    <= {ADDR_W{1'b0}};
      addr_b_q    <= {ADDR_W{1'b0}};
      addr_c_q    <= {ADDR_W{1'b0}};
      addr_out_q  <= {ADDR_W{1'b0}};
      trig_q      <= 1'b0;
      gcnt_q      <= {GCNT_W{1'b0}};
      tcnt_q      <= {TCNT_W{1'b0}};
      op_a_q      <= {DATA_W{1'b0}};
      op_b_q      <= {DATA_W{1'b0}};
      op_c_q      <= {DATA_W{1'b0}};
      op_valid_q  <= 1'b0;
      req_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      addr_c_q    <= addr_c_d;
      addr_out_q  <= addr_out_d;
      trig_q      <= trig_d;
      gcnt_q      <= gcnt_d;
      tcnt_q      <= tcnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_c_q      <= op_c_d;
      op_valid_q  <= op_valid_d;
      req_ready_q <= req_ready_d;
      err_q       <= err_d;
    end
  end

  assign reqReady    = req_ready_q;
  assign triggerOutr = trig_q;
  assign addrOut     = addr_out_q;
  assign opValid     = op_valid_q;
  assign opA         = op_a_q;
  assign opB         = op_b_q;
  assign opC         = op_c_q;
  assign timeoutErr  = err_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a behavioural register-bank model.
module tb_operand_fetch;
  import regbank_pkg::*;

  localparam int G  = 2;
  localparam int S  = 2;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [3:0]  addrA = 4'd0, addrB = 4'd0, addrC = 4'd0;
  logic [2:0]  useMask = 3'b000;
  logic        triggerOutr;
  logic [3:0]  addrOut;
  logic        readyIn;
  logic [31:0] dataIn = 32'd0;
  logic        opValid;
  logic [31:0] opA, opB, opC;
  logic        opAck = 1'b0;
  logic        timeoutErr;

  operand_fetch #(.GUARD_CYCLES(G), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .addrA(addrA), .addrB(addrB), .addrC(addrC), .useMask(useMask),
    .triggerOutr(triggerOutr), .addrOut(addrOut), .readyIn(readyIn),
    .dataIn(dataIn), .opValid(opValid), .opA(opA), .opB(opB), .opC(opC),
    .opAck(opAck), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: every trigger edge is one read of mem[addrOut]
  logic [31:0] mem [16];
  logic [3:0]  addr_log [256];
  int          edges = 0;
  logic        hang_en = 1'b0;
  int          hang_edge = 0;

  assign readyIn = !(hang_en && (edges >= hang_edge));

  always @(triggerOutr) begin
    if (!reset) begin
      addr_log[edges[7:0]] = addrOut;
      dataIn = mem[addrOut];
      edges = edges + 1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  logic model_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0] mask;
    logic [3:0] a, b, c;
    int         hang;
    int         acc;
    int         base;
  } req_t;

  req_t sb[$];

  task automatic send_req(input logic [2:0] mask, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input int hang);
    req_t r;
    int t;
    @(negedge clk);
    useMask = mask; addrA = a; addrB = b; addrC = c; reqValid = 1'b1;
    t = 0;
    while (!reqReady && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!reqReady) chk("req_ready_wait", 32'(reqReady), 32'd1);
    r.mask = mask; r.a = a; r.b = b; r.c = c; r.hang = hang; r.base = edges;
    if (hang >= 0) begin
      hang_edge = edges + hang + 1;
      hang_en = 1'b1;
    end
    @(posedge clk); #1;
    r.acc = cyc;
    sb.push_back(r);
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  task automatic get_result();
    req_t r;
    logic [31:0] ev [3];
    logic [3:0]  ea [3];
    logic [3:0]  ad;
    int lat, nf, t;
    logic tout;
    r = sb.pop_front();
    ev[0] = 32'd0; ev[1] = 32'd0; ev[2] = 32'd0;
    ea[0] = 4'd0; ea[1] = 4'd0; ea[2] = 4'd0;
    lat = 1; nf = 0; tout = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (r.mask[k] && !tout) begin
        ad = (k == 0) ? r.a : (k == 1) ? r.b : r.c;
        ea[nf] = ad;
        if (nf == r.hang) begin
          tout = 1'b1;
          lat += 2 + G + TO;
        end else begin
          lat += 3 + G;
          ev[k] = mem[ad];
        end
        nf++;
      end
    end
    if (tout) model_err = 1'b1;
    t = 0;
    while (!opValid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("op_valid_seen", 32'(opValid), 32'd1);
    chk("latency", 32'(cyc - r.acc), 32'(lat));
    chk("opA", opA, ev[0]);
    chk("opB", opB, ev[1]);
    chk("opC", opC, ev[2]);
    chk("timeout_err", 32'(timeoutErr), 32'(model_err));
    chk("trigger_edges", 32'(edges - r.base), 32'(nf));
    for (int k = 0; k < nf; k++) chk("read_addr", 32'(addr_log[8'(r.base + k)]), 32'(ea[k]));
  endtask

  task automatic ack();
    @(negedge clk);
    opAck = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", 32'(opValid), 32'd0);
    @(negedge clk);
    opAck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_t r1, r2;
    int fall, t;
    for (int i = 0; i < 16; i++) mem[i] = 32'h100 + 32'(i);
    mem[1] = 32'h11; mem[2] = 32'h22; mem[3] = 32'h33;
    mem[REG_PC] = 32'h0000_0040;

    // Reset values
    #1;
    chk("rst_req_ready", 32'(reqReady), 32'd0);
    chk("rst_trigger", 32'(triggerOutr), 32'd0);
    chk("rst_addr_out", 32'(addrOut), 32'd0);
    chk("rst_op_valid", 32'(opValid), 32'd0);
    chk("rst_opA", opA, 32'd0);
    chk("rst_timeout", 32'(timeoutErr), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(reqReady), 32'd1);

    // Full operand set, then hold without acknowledge
    send_req(3'b111, 4'd1, 4'd2, 4'd3, -1);
    get_result();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(opValid), 32'd1);
      chk("hold_opB", opB, 32'h22);
    end
    ack();

    // Empty mask: no bank access
    send_req(3'b000, 4'd5, 4'd6, 4'd7, -1);
    get_result();
    @(negedge clk);
    opAck = 1'b1;
    @(posedge clk); #1;
    opAck = 1'b0;
    chk("empty_valid_drop", 32'(opValid), 32'd0);
    @(posedge clk); #1;
    chk("empty_ready_after", 32'(reqReady), 32'd1);

    // Operand C only, from the PC register
    send_req(3'b100, 4'd1, 4'd2, REG_PC, -1);
    get_result();
    ack();

    // Bank never answers: timeout, then sticky error over a good request
    send_req(3'b001, 4'd2, 4'd0, 4'd0, 0);
    get_result();
    hang_en = 1'b0;
    ack();
    send_req(3'b011, 4'd1, 4'd2, 4'd0, -1);
    get_result();
    ack();

    // Reset while waiting on operand B
    send_req(3'b111, 4'd1, 4'd2, 4'd3, 1);
    r1 = sb.pop_back();
    t = 0;
    while (edges < r1.base + 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("b_toggle_seen", 32'(edges - r1.base), 32'd2);
    repeat (4) @(negedge clk);
    chk("pre_rst_trigger", 32'(triggerOutr), 32'(edges[0]));
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(opValid), 32'd0);
    chk("mid_rst_trigger", 32'(triggerOutr), 32'd0);
    chk("mid_rst_timeout", 32'(timeoutErr), 32'd0);
    chk("mid_rst_ready", 32'(reqReady), 32'd0);
    hang_en = 1'b0;
    model_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready_after", 32'(reqReady), 32'd1);
    send_req(3'b101, 4'd3, 4'd0, 4'd1, -1);
    get_result();
    ack();

    // Back-to-back with reqValid held high
    @(negedge clk);
    useMask = 3'b001; addrA = 4'd1; addrB = 4'd0; addrC = 4'd0; reqValid = 1'b1;
    r1.mask = 3'b001; r1.a = 4'd1; r1.b = 4'd0; r1.c = 4'd0; r1.hang = -1; r1.base = edges;
    @(posedge clk); #1;
    r1.acc = cyc;
    sb.push_back(r1);
    @(negedge clk);
    useMask = 3'b110; addrA = 4'd0; addrB = 4'd2; addrC = 4'd3;
    get_result();
    opAck = 1'b1;
    @(posedge clk); #1;
    chk("b2b_valid_drop", 32'(opValid), 32'd0);
    fall = cyc;
    r2.mask = 3'b110; r2.a = 4'd0; r2.b = 4'd2; r2.c = 4'd3; r2.hang = -1; r2.base = edges;
    @(negedge clk);
    opAck = 1'b0;
    chk("b2b_ready", 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    r2.acc = cyc;
    chk("b2b_accept_gap", 32'(r2.acc - fall), 32'd1);
    chk("b2b_ready_low", 32'(reqReady), 32'd0);
    sb.push_back(r2);
    @(negedge clk);
    reqValid = 1'b0;
    get_result();
    chk("b2b_total_edges", 32'(edges - r1.base), 32'd3);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Clocked requester that drives the register bank's toggle-triggered read port on behalf of the decoder.
- Accepts one decoded instruction's operand set: up to three 4-bit register addresses (A, B, C) plus a use-mask.
- Issues one read per selected register, in order A, B, C. Each read is a level toggle on the trigger line.
- After each toggle, waits for the bank's ready level, captures the 32-bit data, and presents the full operand set to the issuer with a valid/ack handshake.

Parameters:
- GUARD_CYCLES, 2, cycles after a trigger toggle during which readyIn is ignored. Must be >= SYNC_STAGES; elaboration error otherwise.
- SYNC_STAGES, 2, flops in the readyIn synchronizer.
- TIMEOUT, 64, maximum WAIT cycles per operand before abort.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- reqValid  in  1  decoder presents an operand request.
- reqReady  out  1  block can accept a request. High only in IDLE.
- addrA  in  4  register index, operand A.
- addrB  in  4  register index, operand B.
- addrC  in  4  register index, operand C.
- useMask  in  3  bit0=A, bit1=B, bit2=C. Selects which operands to fetch.
- triggerOutr  out  1  read trigger to the bank. Each edge is one read request.
- addrOut  out  4  read address to the bank.
- readyIn  in  1  bank ready level, asynchronous to clk.
- dataIn  in  32  bank read data. Stable whenever readyIn is high.
- opValid  out  1  operand set valid.
- opA  out  32  operand A value.
- opB  out  32  operand B value.
- opC  out  32  operand C value.
- opAck  in  1  issuer consumed the operand set.
- timeoutErr  out  1  sticky: a read timed out.

Behaviour:
- Reset values: reqReady=0 during reset, then 1 from the first edge after release. triggerOutr=0, addrOut=0, opValid=0, opA=opB=opC=0, timeoutErr=0, state=IDLE, all counters=0.
- Reset mid-operation: all of the above apply immediately. Any toggle lost or generated by reset is harmless, since bank reads have no side effects.
- Handshake: a request is accepted on a clk edge where reqValid && reqReady. On acceptance, addresses and mask are latched and opA/B/C are cleared to 0. Inputs are ignored outside IDLE.
- IDLE:
  - On accept with mask!=0 -> ADDR. Current operand = lowest set mask bit.
  - On accept with mask==0 -> DONE (no bank access).
- ADDR (1 cycle): addrOut <= latched address of the current operand -> TOGGLE. Address is therefore stable one full cycle before the trigger edge.
- TOGGLE (1 cycle): triggerOutr <= ~triggerOutr. Guard counter loaded -> GUARD.
- GUARD (GUARD_CYCLES cycles): synchronized ready is ignored -> WAIT.
- WAIT:
  - If synchronized readyIn==1: capture dataIn into the current operand register. Then go to ADDR for the next set mask bit, or DONE if none remain.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT: set timeoutErr and go to DONE. Unfetched operands stay 0.
- DONE: opValid=1, holding opA/B/C. When opAck is sampled high -> IDLE, and opValid drops on the same edge. A new request is acceptable from the following cycle. opAck outside DONE is ignored.
- Latency:
  - Each fetched operand costs 3+GUARD_CYCLES cycles, provided ready is already high at the first WAIT cycle.
  - opValid rises on the edge after the last capture.
  - Defaults: 1 operand -> opValid 6 edges after the accept edge; 3 operands -> 16 edges.
- Register 15 is treated as an ordinary index. The bank supplies the PC value; no special casing here.
- Bit order is fixed A, B, C. Skipped operands read 0.
- addrOut holds its last value between reads. triggerOutr keeps its level between reads; only edges carry meaning.

Decomposition:
- Shared package regbank_pkg:
  - state enum: IDLE, ADDR, TOGGLE, GUARD, WAIT, DONE
  - operand index constants: OP_A=0, OP_B=1, OP_C=2
  - REG_PC=15
  - data width 32, address width 4
- Sub-module level_sync (SYNC_STAGES-flop synchronizer with asynchronous reset to 0) for readyIn.
- Everything else stays in operand_fetch.

Test Plan:
- Reset release, then request useMask=3'b111, addrA=1, addrB=2, addrC=3, with bank model mem[1..3]=0x11,0x22,0x33 -> exactly 3 trigger edges with addrOut 1,2,3. opValid on edge 16 after accept, opA=0x11, opB=0x22, opC=0x33. Hold opAck low 5 cycles -> opValid stays high with values unchanged.
- useMask=3'b000 -> no trigger edge. opValid next edge, all operands 0. opAck -> reqReady=1 on the following cycle.
- useMask=3'b100, addrC=15, bank PC=0x0000_0040 -> one toggle, addrOut=15, opC=0x40, opA=opB=0, opValid on edge 6.
- Bank model holds readyIn low indefinitely after a toggle -> after GUARD+TIMEOUT cycles timeoutErr=1 and opValid=1 with that operand 0. timeoutErr stays 1 across later successful requests until reset.
- Assert reset during WAIT of operand B -> immediately opValid=0, triggerOutr=0, timeoutErr=0. After release, reqReady=1 and a fresh request completes normally.
- Back-to-back: reqValid held high with opAck asserted in DONE -> second request accepted exactly one cycle after opValid falls. Trigger-edge count matches the total number of mask bits across both requests.
